// File: rtl/seq_chk_ctrl_pkg.sv
// Shared types and constants for the sequence-checker controller slice.
// Optional build macro SEQ_CHK_CTRL_STOP_ON_HIT_EN is consumed in seq_chk_ctrl.sv.
package seq_chk_pkg;

    localparam int              CNT_W           = 8;
    localparam logic [CNT_W-1:0] NO_HIT         = 8'hFF;
    localparam int              CHK_LAT_DEFAULT = 1;

    // Oldest bit first: the checker flags the arrival order 1,0,1,1.
    localparam logic [3:0]      CHK_PATTERN     = 4'b1011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/seq_chk_ctrl_if.sv
// Host-side bundle of seq_chk_ctrl: window request/abort, serial channels and results.
interface seq_chk_ctrl_if
    import seq_chk_pkg::*;
#(
    parameter int N_CH = 4
);
    logic             start;
    logic             abort;
    logic [1:0]       chan_sel;
    logic [7:0]       win_len;
    logic [N_CH-1:0]  din_ch;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] first_hit_pos;

    modport master (
        output start, abort, chan_sel, win_len, din_ch,
        input  busy, done, hit_cnt, first_hit_pos
    );

    modport slave (
        input  start, abort, chan_sel, win_len, din_ch,
        output busy, done, hit_cnt, first_hit_pos
    );

endinterface

// File: rtl/seq_chk_fsm.sv
// Serial sequence checker: flags CHK_PATTERN on din, success_flag delayed by CHK_LAT cycles.
module seq_chk_fsm
    import seq_chk_pkg::*;
#(
    parameter int CHK_LAT = CHK_LAT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic success_flag
);

    logic [2:0] sr_reg;
    logic       match;

    assign match = ({sr_reg, din} == CHK_PATTERN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_reg <= '0;
        end else begin
            sr_reg <= {sr_reg[1:0], din};
        end
    end

    generate
        if (CHK_LAT == 0) begin : g_comb
            assign success_flag = match;
        end else begin : g_pipe
            logic [CHK_LAT-1:0] pipe_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pipe_reg <= '0;
                end else begin
                    pipe_reg[0] <= match;
                    for (int i = 1; i < CHK_LAT; i++) begin
                        pipe_reg[i] <= pipe_reg[i-1];
                    end
                end
            end

            assign success_flag = pipe_reg[CHK_LAT-1];
        end
    endgenerate

endmodule

// File: rtl/seq_chk_satcnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module seq_chk_satcnt
    import seq_chk_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != '1)) begin
            cnt_reg <= cnt_reg + W'(1);
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/seq_chk_ctrl.sv
// Check-window controller: clears the checker, streams one channel for win_len bits, counts hits.
// Build macro SEQ_CHK_CTRL_STOP_ON_HIT_EN ends the window on the first counted hit.
module seq_chk_ctrl
    import seq_chk_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int CHK_LAT = CHK_LAT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_chk_ctrl_if.slave host,
    output logic          chk_din,
    output logic          chk_rst_n,
    input  logic          chk_success
);

    localparam logic [8:0] LAT9 = 9'(CHK_LAT);

    state_t           state_reg;
    state_t           state_next;
    logic [1:0]       sel_reg;
    logic [8:0]       len_reg;
    logic [8:0]       bit_cnt_reg;
    logic [CNT_W-1:0] first_pos_reg;
    logic             chk_rst_n_reg;
    logic [3:0]       din_pad;
    logic             accept;
    logic             in_window;
    logic             hit;
    logic             first_hit;
    logic             clr_results;
    logic             run_last;
    logic             drain_last;
    logic             stop_hit;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] hit_pos;

    // chan_sel is two bits wide; channels the block does not have read as 0.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pad
            if (gi < N_CH) begin : g_ch
                assign din_pad[gi] = host.din_ch[gi];
            end else begin : g_zero
                assign din_pad[gi] = 1'b0;
            end
        end
    endgenerate

    assign accept      = (state_reg == ST_IDLE) && host.start && !host.abort;
    assign in_window   = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
    assign hit         = in_window && chk_success;
    assign first_hit   = hit && (hit_cnt == '0);
    assign clr_results = accept || host.abort;
    assign run_last    = (bit_cnt_reg == len_reg - 9'd1);
    assign drain_last  = (bit_cnt_reg == len_reg + LAT9 - 9'd1);

    // bit_cnt keeps counting through DRAIN so a late flag still maps back to its bit.
    // Flags within the first CHK_LAT cycles cannot come from window data; clamp to bit 0.
    assign hit_pos = (bit_cnt_reg < LAT9) ? '0 : CNT_W'(bit_cnt_reg - LAT9);

`ifdef SEQ_CHK_CTRL_STOP_ON_HIT_EN
    assign stop_hit = first_hit;
`else
    assign stop_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:  if (host.start) state_next = ST_CLEAR;
            ST_CLEAR: state_next = ST_RUN;
            ST_RUN: begin
                if (stop_hit) begin
                    state_next = ST_DONE;
                end else if (run_last) begin
                    state_next = (CHK_LAT == 0) ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: if (stop_hit || drain_last) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        if (host.abort) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_reg       <= '0;
            len_reg       <= '0;
            bit_cnt_reg   <= '0;
            first_pos_reg <= NO_HIT;
            chk_rst_n_reg <= 1'b0;
        end else begin
            chk_rst_n_reg <= (state_next != ST_CLEAR);
            if (accept) begin
                sel_reg     <= host.chan_sel;
                len_reg     <= {(host.win_len == 8'd0), host.win_len};
                bit_cnt_reg <= '0;
            end else if (in_window) begin
                bit_cnt_reg <= bit_cnt_reg + 9'd1;
            end
            if (clr_results) begin
                first_pos_reg <= NO_HIT;
            end else if (first_hit) begin
                first_pos_reg <= hit_pos;
            end
        end
    end

    seq_chk_satcnt #(.W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_results),
        .inc   (hit),
        .cnt   (hit_cnt)
    );

    assign chk_din            = (state_reg == ST_RUN) ? din_pad[sel_reg] : 1'b0;
    assign chk_rst_n          = chk_rst_n_reg;
    assign host.busy          = (state_reg != ST_IDLE);
    assign host.done          = (state_reg == ST_DONE);
    assign host.hit_cnt       = hit_cnt;
    assign host.first_hit_pos = first_pos_reg;

endmodule

// File: tb/tb_seq_chk_ctrl.sv
// Scoreboard bench for seq_chk_ctrl driving a real seq_chk_fsm checker.
module tb_seq_chk_ctrl;
    import seq_chk_pkg::*;

    localparam int N_CH = 4;
    localparam int LAT  = CHK_LAT_DEFAULT;
    localparam logic [3:0] TB_PAT = 4'b1011;
`ifdef SEQ_CHK_CTRL_STOP_ON_HIT_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    typedef struct {
        string name;
        int    done_cyc;
        int    hits;
        int    first;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b1;
    logic   chk_din;
    logic   chk_rst_n;
    logic   chk_flag;
    logic   chk_success;
    logic   force_hit = 1'b0;
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    bit     mon_en = 1'b0;
    exp_t   exp_q[$];

    logic [15:0]  win_bits  = 16'h1A34;
    logic [19:0]  stop_bits = 20'h000D0;
    logic [255:0] rnd_bits;
    int           s;
    int           n;
    int           exp_hits;
    int           exp_first;

    seq_chk_ctrl_if #(.N_CH(N_CH)) host ();

    seq_chk_ctrl #(.N_CH(N_CH), .CHK_LAT(LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .host        (host),
        .chk_din     (chk_din),
        .chk_rst_n   (chk_rst_n),
        .chk_success (chk_success)
    );

    seq_chk_fsm #(.CHK_LAT(LAT)) u_chk (
        .clk          (clk),
        .rst_n        (chk_rst_n),
        .din          (chk_din),
        .success_flag (chk_flag)
    );

    assign chk_success = force_hit | chk_flag;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_done(input string name, input int dc, input int h, input int f);
        exp_t e;
        e.name = name; e.done_cyc = dc; e.hits = h; e.first = f;
        exp_q.push_back(e);
    endtask

    // Called on a negedge; returns with the bench at the negedge of the CLEAR cycle.
    task automatic do_start(input logic [1:0] ch, input logic [7:0] len, output int sc);
        host.chan_sel = ch;
        host.win_len  = len;
        host.start    = 1'b1;
        sc = cyc;
        @(negedge clk);
        host.start = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en && host.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", int'(host.done), 0);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_done_cyc"}, cyc, e.done_cyc);
                check({e.name, "_hit_cnt"}, int'(host.hit_cnt), e.hits);
                check({e.name, "_first_pos"}, int'(host.first_hit_pos), e.first);
                $display("done %s at cycle %0d hit_cnt %0d first_hit_pos %0d",
                         e.name, cyc, host.hit_cnt, host.first_hit_pos);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        host.start = 1'b0; host.abort = 1'b0; host.chan_sel = '0;
        host.win_len = '0; host.din_ch = '0;

        // Reset
        #12 rst_n = 1'b0;
        #8;
        check("rst_busy", int'(host.busy), 0);
        check("rst_done", int'(host.done), 0);
        check("rst_hit_cnt", int'(host.hit_cnt), 0);
        check("rst_first_pos", int'(host.first_hit_pos), 255);
        check("rst_chk_rst_n", int'(chk_rst_n), 0);
        check("rst_chk_din", int'(chk_din), 0);
        #13 rst_n = 1'b1;
        #1 check("rst_chk_rst_n_before_edge", int'(chk_rst_n), 0);
        @(negedge clk);
        check("rst_chk_rst_n_after_edge", int'(chk_rst_n), 1);
        check("rst_busy_after", int'(host.busy), 0);
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // 16-bit window on channel 2, two pattern hits ending at bits 5 and 12
        do_start(2'd2, 8'd16, s);
        if (STOP) expect_done("window", s + 2 + 5 + LAT + 1, 1, 5);
        else      expect_done("window", s + 2 + 16 + LAT, 2, 5);
        check("clear_chk_rst_low", int'(chk_rst_n), 0);
        force_hit = 1'b1;
        @(negedge clk);
        force_hit = 1'b0;
        check("clear_one_cycle", int'(chk_rst_n), 1);
        for (int i = 0; i < 16; i++) begin
            host.din_ch = {~win_bits[i], win_bits[i], ~win_bits[i], ~win_bits[i]};
            @(negedge clk);
        end
        host.din_ch = '0;
        repeat (LAT) @(negedge clk);
        force_hit = 1'b1;
        @(negedge clk);
        force_hit = 1'b0;
        repeat (3) @(negedge clk);
        check("window_hold_hits", int'(host.hit_cnt), STOP ? 1 : 2);
        check("window_hold_first", int'(host.first_hit_pos), 5);

        // win_len = 0 means 256 bits; pattern hits modelled from the drawn stream
        for (int i = 0; i < 256; i++) rnd_bits[i] = STOP ? 1'b0 : 1'($urandom_range(0, 1));
        exp_hits = 0; exp_first = 255;
        for (int j = 3; j < 256; j++) begin
            if ({rnd_bits[j-3], rnd_bits[j-2], rnd_bits[j-1], rnd_bits[j]} == TB_PAT) begin
                if (exp_hits == 0) exp_first = j;
                exp_hits++;
            end
        end
        do_start(2'd1, 8'd0, s);
        expect_done("zero_len", s + 2 + 256 + LAT, exp_hits, exp_first);
        n = 0;
        if (host.busy) n++;
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            host.din_ch = {2'b00, rnd_bits[i], 1'b0};
            if (host.busy) n++;
            @(negedge clk);
        end
        host.din_ch = '0;
        for (int k = 0; k < 10 && host.busy; k++) begin
            n++;
            @(negedge clk);
        end
        check("zero_len_busy_cycles", n, 1 + 256 + LAT + 1);
        repeat (2) @(negedge clk);

        // Restart during RUN is ignored; abort at bit 5 discards the window
        do_start(2'd0, 8'd20, s);
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            host.din_ch = (!STOP && i < 4) ? {3'b000, TB_PAT[3-i]} : '0;
            host.start  = (i == 3);
            host.abort  = (i == 5);
            if (i == 4) check("restart_ignored", int'(chk_rst_n), 1);
            @(negedge clk);
        end
        host.abort  = 1'b0;
        host.start  = 1'b0;
        host.din_ch = '0;
        check("abort_busy", int'(host.busy), 0);
        check("abort_hit_cnt", int'(host.hit_cnt), 0);
        check("abort_first_pos", int'(host.first_hit_pos), 255);
        repeat (30) @(negedge clk);
        check("abort_no_queued_start", int'(host.busy), 0);

        // Checker flag held high for 300 cycles over a 256-bit window
        force_hit = 1'b1;
        do_start(2'd3, 8'd0, s);
        if (STOP) expect_done("saturate", s + 3, 1, 0);
        else      expect_done("saturate", s + 2 + 256 + LAT, 255, 0);
        repeat (299) @(negedge clk);
        force_hit = 1'b0;
        repeat (5) @(negedge clk);
        check("saturate_idle", int'(host.busy), 0);

        // Single hit ending at bit 7 of a 20-bit window on channel 0
        do_start(2'd0, 8'd20, s);
        if (STOP) expect_done("hit_bit7", s + 2 + 7 + LAT + 1, 1, 7);
        else      expect_done("hit_bit7", s + 2 + 20 + LAT, 1, 7);
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            host.din_ch = {3'b000, stop_bits[i]};
            @(negedge clk);
        end
        host.din_ch = '0;
        repeat (LAT + 5) @(negedge clk);

        check("all_done_seen", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_chk_ctrl.md
SEQ_CHK_CTRL -- requirements
Module: seq_chk_ctrl

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, giving the number of serial input channels.
REQ-002 The block SHALL have parameter CHK_LAT, default 1, range 0..3, giving the checker's din-to-success_flag latency in cycles.
REQ-003 clk  input  1  Single clock; all logic is on the rising edge.
REQ-004 rst_n  input  1  Reset, asynchronous and active-low.
REQ-005 start  input  1  One-cycle request to run a check window; honoured only in IDLE.
REQ-006 abort  input  1  Return to IDLE from any state.
REQ-007 chan_sel  input  2  Channel to check; latched on an accepted start.
REQ-008 win_len  input  8  Window length in bits; latched on an accepted start; 0 means 256.
REQ-009 din_ch  input  N_CH  Serial input channels.
REQ-010 chk_din  output  1  Serial bit driven to the sequence checker.
REQ-011 chk_rst_n  output  1  Registered active-low clear for the checker.
REQ-012 chk_success  input  1  success_flag returned by the checker.
REQ-013 busy  output  1  High in every state except IDLE.
REQ-014 done  output  1  One-cycle pulse when a window completes.
REQ-015 hit_cnt  output  8  Count of chk_success cycles in the window; saturates at 255.
REQ-016 first_hit_pos  output  8  Bit index (0-based) of the first hit; 8'hFF if no hit.

Function
REQ-017 The FSM SHALL have the states IDLE, CLEAR, RUN, DRAIN and DONE.
REQ-018 IDLE transition: start=1 latches chan_sel and win_len, clears the results and bit_cnt, then moves to CLEAR.
REQ-019 CLEAR transition: chk_rst_n=0 for exactly one cycle, then move to RUN.
REQ-020 RUN: chk_din=din_ch[sel_q] (combinational mux); in every other state chk_din=0.
REQ-021 RUN: bit_cnt increments once per cycle.
REQ-022 RUN exit: after win_len cycles (256 when win_len=0), move to DRAIN.
REQ-023 DRAIN: lasts CHK_LAT cycles with chk_din=0, then move to DONE; when CHK_LAT=0, RUN goes directly to DONE.
REQ-024 Hit counting: chk_success=1 in RUN or DRAIN increments hit_cnt (saturating); the first such cycle captures first_hit_pos = bit_cnt - CHK_LAT.
REQ-025 DONE: done=1 for exactly one cycle, then move to IDLE; hit_cnt and first_hit_pos hold until the next accepted start.
REQ-026 start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-027 abort=1 in any state: next state IDLE, no done pulse, results cleared to hit_cnt=0 and first_hit_pos=8'hFF; abort takes priority over start in the same cycle.
REQ-028 chk_success outside RUN and DRAIN SHALL be ignored.

Reset
REQ-029 While rst_n=0 the block SHALL be in IDLE with busy=0, done=0, hit_cnt=0, first_hit_pos=8'hFF, chk_rst_n=0 and chk_din=0.
REQ-030 Reset mid-window SHALL discard the window without a done pulse; chk_rst_n SHALL return to 1 on the first clock edge after rst_n deasserts.

Configuration
REQ-031 Macro SEQ_CHK_CTRL_STOP_ON_HIT_EN defined: the first counted hit moves the FSM to DONE on the next cycle, from RUN or DRAIN, so hit_cnt=1 at done.
REQ-032 Macro SEQ_CHK_CTRL_STOP_ON_HIT_EN undefined: the full window always runs.

Structure
REQ-033 Package seq_chk_pkg SHALL hold the state encoding, CNT_W=8, NO_HIT=8'hFF and the default CHK_LAT.
REQ-034 The saturating hit counter SHALL be sub-module seq_chk_satcnt; the FSM and bit counter SHALL stay in seq_chk_ctrl.
REQ-035 The bench SHALL instantiate seq_chk_fsm with CHK_LAT matching its latency.

Verification
REQ-036 Reset: rst_n=0 at 12 ns, 1 at 33 ns -> IDLE, busy=0, first_hit_pos=8'hFF, chk_rst_n=0 during reset, then 1.
REQ-037 Window: start, chan_sel=2, win_len=16, din_ch[2] driven with the target pattern twice -> chk_rst_n low for 1 cycle, done at cycle 2+16+CHK_LAT after start, hit_cnt=2, correct first_hit_pos.
REQ-038 Zero length: win_len=0 with random din -> exactly 256 RUN cycles, and busy=1 for 1+256+CHK_LAT+1 cycles.
REQ-039 Abort and start during busy: start repeated mid-RUN is ignored; abort at bit 5 -> IDLE next cycle, no done, hit_cnt=0.
REQ-040 Saturation: chk_success forced to 1 for 300 cycles -> hit_cnt=255, first_hit_pos=0.
REQ-041 Stop on hit: SEQ_CHK_CTRL_STOP_ON_HIT_EN defined, hit at bit 7 -> done occurs CHK_LAT+1 cycles after bit 7, hit_cnt=1.
